// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register with a skid buffer so in_ready is registered and
// carries no combinational path from out_ready.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] StEmpty = 2'b00;
  localparam logic [1:0] StBusy  = 2'b01;
  localparam logic [1:0] StFull  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush only drops occupancy; the data registers keep their contents.
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_valid) begin
            main_d  = in_data;
            state_d = StBusy;
          end
        end
        StBusy: begin
          if (in_valid && out_ready) begin
            main_d = in_data;
          end else if (in_valid) begin
            skid_d  = in_data;
            state_d = StFull;
          end else if (out_ready) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so in_valid is ignored.
          if (out_ready) begin
            main_d  = skid_q;
            state_d = StBusy;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    // Handshake flags are precomputed from the next state and registered.
    in_ready_d  = (state_d != StFull);
    out_valid_d = (state_d != StEmpty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule
